// File: rtl/rk2_pkg.sv
// Shared definitions for the RK2 frame link: state encoding, widths, default header.
package rk2_pkg;

  localparam int unsigned RK2_BYTE_W = 8;
  localparam int unsigned RK2_WORD_W = 16;

  localparam logic [RK2_BYTE_W-1:0] RK2_HEADER_DEF = 8'hCA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HI,
    ST_LO,
    ST_WAIT,
    ST_GAP
  } rk2_state_e;

  function automatic int unsigned rk2_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rk2_down_counter.sv
// Loadable down counter with zero flag; saturates at zero.
module rk2_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rk2_frame_tx.sv
// Frame transmitter: sends HEADER, word[15:8], word[7:0] with cs low, then waits
// for ack/err with timeout, retrying up to MAX_TRY attempts with a cs-high gap.
module rk2_frame_tx
  import rk2_pkg::*;
#(
  parameter logic [RK2_BYTE_W-1:0] HEADER  = RK2_HEADER_DEF,
  parameter int unsigned           MAX_TRY = 3,
  parameter int unsigned           TIMEOUT = 8,
  parameter int unsigned           GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [RK2_WORD_W-1:0] req_data,
  output logic                  req_ready,
  output logic                  cs,
  output logic [RK2_BYTE_W-1:0] d_out,
  input  logic                  ack,
  input  logic                  err,
  output logic                  done,
  output logic                  fail,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(rk2_max(TIMEOUT, GAP) + 1);
  localparam int unsigned TRY_W = $clog2(MAX_TRY + 1);

  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRY);

  rk2_state_e state_q, state_d;
  logic [RK2_WORD_W-1:0] data_q, data_d;
  logic [TRY_W-1:0]      try_q, try_d;
  logic                  resend_q, resend_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic                  rdy_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             attempt_bad;

  // One counter serves both WAIT timeout and GAP spacing; the states never overlap.
  rk2_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign req_ready = rdy_q && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign fail      = fail_q;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    try_d       = try_q;
    resend_d    = resend_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    attempt_bad = 1'b0;
    cs          = 1'b1;
    d_out       = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          data_d   = req_data;
          try_d    = TRY_W'(1);
          resend_d = 1'b0;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        cs      = 1'b0;
        d_out   = HEADER;
        state_d = ST_HI;
      end
      ST_HI: begin
        cs      = 1'b0;
        d_out   = data_q[15:8];
        state_d = ST_LO;
      end
      ST_LO: begin
        cs       = 1'b0;
        d_out    = data_q[7:0];
        state_d  = ST_WAIT;
        cnt_load = 1'b1;
        cnt_val  = TO_LOAD;
      end
      ST_WAIT: begin
        // err wins over a simultaneous ack
        if (err) begin
          attempt_bad = 1'b1;
        end else if (ack) begin
          done_d   = 1'b1;
          resend_d = 1'b0;
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end else if (cnt_zero) begin
          attempt_bad = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
        if (attempt_bad) begin
          if (try_q < TRY_MAX) begin
            try_d    = try_q + TRY_W'(1);
            resend_d = 1'b1;
          end else begin
            fail_d   = 1'b1;
            resend_d = 1'b0;
          end
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = resend_q ? ST_HDR : ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      try_q    <= '0;
      resend_q <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      try_q    <= try_d;
      resend_q <= resend_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rk2_frame_tx.sv
// Scoreboard bench for rk2_frame_tx: driver queues expected bytes/pulses, a
// negedge monitor pops and compares whenever cs is low or done/fail pulse.
module tb_rk2_frame_tx;

  localparam int unsigned TRY_C = 3;
  localparam int unsigned TO_C  = 8;
  localparam int unsigned GAP_C = 2;

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_FAIL = 2'd2;

  localparam logic [1:0] R_ACK  = 2'd0;
  localparam logic [1:0] R_ERR  = 2'd1;
  localparam logic [1:0] R_BOTH = 2'd2;
  localparam logic [1:0] R_NONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] b;
  } exp_t;

  logic        clk, rst, req_valid, req_ready, cs, ack, err, done, fail, busy;
  logic [15:0] req_data;
  logic [7:0]  d_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rk2_frame_tx #(
    .HEADER  (8'hCA),
    .MAX_TRY (TRY_C),
    .TIMEOUT (TO_C),
    .GAP     (GAP_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cs        (cs),
    .d_out     (d_out),
    .ack       (ack),
    .err       (err),
    .done      (done),
    .fail      (fail),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void expect_evt(input logic [1:0] kind, input logic [7:0] b, input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected kind=%0d byte=%0h with empty scoreboard at %0t", nm, kind, b, $time);
    end else begin
      e = sb.pop_front();
      chk(nm, {22'd0, kind, b}, {22'd0, e.kind, e.b});
    end
  endfunction

  // Monitor
  int unsigned low_run, high_run;
  bit          seen_frame;

  always @(negedge clk) begin
    if (!rst) begin
      low_run    = 0;
      high_run   = 0;
      seen_frame = 0;
    end else begin
      if (!cs) begin
        if (low_run == 0 && seen_frame) chk("gap_ge_GAP", 32'(high_run >= GAP_C), 32'd1);
        low_run++;
        high_run = 0;
        expect_evt(K_BYTE, d_out, "frame_byte");
      end else begin
        if (low_run != 0) begin
          chk("cs_low_len", low_run, 32'd3);
          seen_frame = 1;
        end
        low_run = 0;
        high_run++;
      end
      chk("done_fail_excl", 32'(done & fail), 32'd0);
      if (done) expect_evt(K_DONE, 8'h00, "done_pulse");
      if (fail) expect_evt(K_FAIL, 8'h00, "fail_pulse");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(input logic lvl, input string nm);
    int n = 0;
    while (cs !== lvl && n < 100) begin
      step();
      n++;
    end
    if (cs !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: cs stuck at %0b, required %0b within 100 cycles", nm, cs, lvl);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: req_ready=%0b, required 1 within 100 cycles", req_ready);
    end
  endtask

  // plan holds one 2-bit receiver response per attempt, attempt 0 in bits [1:0]
  task automatic run_word(input logic [15:0] w, input logic [5:0] plan);
    int         n;
    logic [1:0] code;
    bit         finished;
    for (int unsigned a = 0; a < TRY_C; a++) begin
      code = plan[2*a +: 2];
      sb.push_back(exp_t'({K_BYTE, 8'hCA}));
      sb.push_back(exp_t'({K_BYTE, w[15:8]}));
      sb.push_back(exp_t'({K_BYTE, w[7:0]}));
      if (code == R_ACK) break;
      if (a == TRY_C - 1) sb.push_back(exp_t'({K_FAIL, 8'h00}));
    end
    if (plan[2*0 +: 2] == R_ACK || plan[2*1 +: 2] == R_ACK || plan[2*2 +: 2] == R_ACK)
      sb.push_back(exp_t'({K_DONE, 8'h00}));

    wait_ready(n);
    req_valid = 1'b1;
    req_data  = w;
    step();
    req_data  = 16'hDEAD;  // changes while busy must not reach the frame
    finished  = 0;
    for (int unsigned a = 0; a < TRY_C && !finished; a++) begin
      code = plan[2*a +: 2];
      wait_cs(1'b0, "frame_start");
      wait_cs(1'b1, "frame_end");
      req_valid = 1'b0;
      case (code)
        R_ACK: begin
          step();
          ack = 1'b1;
          step();
          ack = 1'b0;
          wait_ready(n);
          chk("ready_after_gap", n, GAP_C);
          finished = 1;
        end
        R_ERR, R_BOTH: begin
          err = 1'b1;
          ack = (code == R_BOTH);
          step();
          err = 1'b0;
          ack = 1'b0;
        end
        default: begin
          n = 0;
          while (cs && !fail && n < 100) begin
            step();
            n++;
          end
          if (a == TRY_C - 1) chk("timeout_to_fail", n, TO_C);
          else                chk("timeout_to_resend", n, TO_C + GAP_C);
        end
      endcase
    end
    wait_ready(n);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_data  = '0;
    ack       = 1'b0;
    err       = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_cs", cs, 1);
    chk("rst_dout", d_out, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    step();
    chk("ready_after_edge", req_ready, 1);

    run_word(16'hFF01, {R_NONE, R_NONE, R_ACK});
    run_word(16'h1234, {R_NONE, R_ACK, R_ERR});
    run_word(16'hBEEF, {R_ERR, R_ERR, R_ERR});
    run_word(16'h0F0F, {R_NONE, R_NONE, R_NONE});
    run_word(16'h5AA5, {R_NONE, R_ACK, R_BOTH});

    // reset during the HI byte
    sb.push_back(exp_t'({K_BYTE, 8'hCA}));
    sb.push_back(exp_t'({K_BYTE, 8'hA5}));
    wait_ready(n);
    req_valid = 1'b1;
    req_data  = 16'hA55A;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_dout", d_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_sb", sb.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (6) step();
    chk("post_rst_idle", busy, 0);
    run_word(16'hC33C, {R_NONE, R_NONE, R_ACK});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/rk2_frame_tx.md
RK2_FRAME_TX -- requirements
Module: rk2_frame_tx

Interface
REQ-001 Parameter HEADER, default 8'hCA: fixed first byte of every frame.
REQ-002 Parameter MAX_TRY, default 3: total transmission attempts per word, original send included.
REQ-003 Parameter TIMEOUT, default 8: cycles in WAIT without ack/err before the attempt counts as error.
REQ-004 Parameter GAP, default 2: minimum cs-high cycles between frames.
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rst  in  1  asynchronous reset, active-low.
REQ-007 req_valid  in  1  upstream has a 16-bit word to send.
REQ-008 req_data  in  16  word to send; sampled only on acceptance.
REQ-009 req_ready  out  1  block can accept a word this cycle.
REQ-010 cs  out  1  frame select, active-low; low exactly for the 3 frame bytes.
REQ-011 d_out  out  8  frame byte while cs=0; 8'h00 while cs=1.
REQ-012 ack  in  1  receiver reports good frame.
REQ-013 err  in  1  receiver reports bad frame.
REQ-014 done  out  1  one-cycle pulse, word delivered.
REQ-015 fail  out  1  one-cycle pulse, word dropped after MAX_TRY attempts.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, HDR, HI, LO, WAIT, GAP.
REQ-018 In IDLE, req_ready=1; in all other states, req_ready=0.
REQ-019 Acceptance occurs on a clock edge with req_valid=1 and req_ready=1; req_data is latched at that edge, the try count is set to 1, and the state moves to HDR.
REQ-020 In HDR, cs=0 and d_out=HEADER; in HI, cs=0 and d_out=latched[15:8]; in LO, cs=0 and d_out=latched[7:0]; each state lasts exactly one cycle.
REQ-021 Latency: the first frame byte appears in the cycle after acceptance, and cs stays low for exactly 3 consecutive cycles.
REQ-022 ack and err are ignored outside WAIT.
REQ-023 In WAIT, ack=1 with err=0 pulses done in the next cycle and moves to GAP with no retry.
REQ-024 In WAIT, err=1 (including when ack=1 in the same cycle) or TIMEOUT cycles elapsed counts as a failed attempt.
REQ-025 After a failed attempt with try < MAX_TRY, try increments, the state goes to GAP, and GAP then returns to HDR to resend the same latched word.
REQ-026 After a failed attempt with try = MAX_TRY, fail pulses and the state goes to GAP, then GAP returns to IDLE.
REQ-027 GAP lasts exactly GAP cycles with cs=1, so no frame starts closer than GAP idle cycles after a previous frame.
REQ-028 done and fail are never high together, and exactly one of them pulses per accepted word.
REQ-029 req_valid changes while busy have no effect; words are not queued.
REQ-030 The timeout counter restarts on every WAIT entry; it is sized for TIMEOUT, and the try counter is sized for MAX_TRY, with no wrap.

Reset
REQ-031 While rst=0, the block is asynchronously forced to IDLE: cs=1, d_out=8'h00, done=0, fail=0, busy=0, req_ready=0, and counters=0.
REQ-032 req_ready goes to 1 from the first clock edge after rst deasserts.
REQ-033 Reset mid-frame aborts the frame immediately, with cs=1 asynchronously and no done or fail pulse.

Structure
REQ-034 Package rk2_pkg holds the state enum, the default HEADER value, and the byte/word width constants, shared with the frame receiver.
REQ-035 One sub-module, rk2_down_counter (loadable, zero flag), is used for both the GAP and TIMEOUT counts.

Verification
REQ-036 Accept word 16'hFF01, then assert ack 2 cycles after LO -> d_out sequence CA,FF,01 with cs low for 3 cycles, done pulses once, and req_ready returns after GAP.
REQ-037 Send word 16'h1234 and assert err on the first WAIT, ack on the second -> two identical frames separated by at least 2 cs-high cycles, then a single done pulse.
REQ-038 Send a word with err asserted on every attempt -> exactly 3 frames, then fail pulses once and done never pulses.
REQ-039 Send a word and never assert ack or err -> after 8 WAIT cycles a resend occurs, and after the 3rd timeout fail pulses.
REQ-040 Assert rst low during the HI byte -> cs=1 and d_out=00 immediately; after release, no stale done or fail pulse, and a new word is sent correctly.
REQ-041 Assert ack and err in the same WAIT cycle -> the attempt is treated as an error and a resend occurs.
